// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - multi-entry valid/allowin stage buffer with flush
//
// Purpose:
//   FIFO-ordered buffer of DEPTH x BUS_W entries placed between two pipeline
//   stages. It keeps accepting from upstream while downstream stalls, until it
//   is full. A flush (wb_ex | wb_ertn) drops every entry. DEPTH=1 behaves like
//   the classic single stage latch.
//
// Optional feature:
//   PIPE_STAGE_BUF_BYPASS_EN - when defined, an empty buffer presents in_bus
//   on out_bus in the same cycle (0-cycle latency). If downstream takes it,
//   the entry is never stored.
//
// Ports:
//   clk          in   clock, all state updates on posedge
//   reset        in   synchronous, active-high reset
//   in_valid     in   upstream bus valid
//   in_bus       in   upstream payload [BUS_W]
//   allowin      out  buffer accepts in_bus this cycle
//   out_valid    out  head entry valid for downstream
//   out_bus      out  head entry payload [BUS_W]
//   out_allowin  in   downstream accepts the head this cycle
//   flush        in   discard all entries
//   count        out  current occupancy [$clog2(DEPTH+1)]

module pipe_stage_buf #(
  parameter int BUS_W = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [BUS_W-1:0]           in_bus,
  output logic                       allowin,
  output logic                       out_valid,
  output logic [BUS_W-1:0]           out_bus,
  input  logic                       out_allowin,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Entry storage is intentionally not reset.
  logic [BUS_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic empty;
  logic bypass;     // head is taken straight from in_bus this cycle
  logic pass_thru;  // bypassed entry consumed downstream, never stored
  logic pop;
  logic push;
  logic store;      // push that lands in storage
  logic deq;        // pop that removes a stored entry

  // Pointers wrap at DEPTH-1, so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    empty = (count_q == '0);

`ifdef PIPE_STAGE_BUF_BYPASS_EN
    bypass    = ~reset & ~flush & empty & in_valid;
    out_valid = ~reset & ~flush & (~empty | in_valid);
    out_bus   = bypass ? in_bus : mem_q[rd_ptr_q];
`else
    bypass    = 1'b0;
    out_valid = ~reset & ~flush & ~empty;
    out_bus   = mem_q[rd_ptr_q];
`endif

    pop       = out_valid & out_allowin;
    // A full buffer still accepts when the head leaves in the same cycle.
    allowin   = ~reset & ((count_q < FULL_CNT) | pop);
    push      = in_valid & allowin & ~flush;
    pass_thru = bypass & out_allowin;
    store     = push & ~pass_thru;
    deq       = pop & ~pass_thru;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (reset || flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (store) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (deq)   rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({store, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // store is already low during reset and flush.
  always_ff @(posedge clk) begin
    if (store) mem_q[wr_ptr_q] <= in_bus;
  end

  assign count = count_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - bench for pipe_stage_buf (DEPTH=2 directed, DEPTH=3 random)

module tb_pipe_stage_buf;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=2 instance
  logic         r2, iv2, oa2, fl2;
  logic [W-1:0] ib2;
  logic         al2, ov2;
  logic [W-1:0] ob2;
  logic [1:0]   cnt2;

  // DEPTH=3 instance
  logic         r3, iv3, oa3, fl3;
  logic [W-1:0] ib3;
  logic         al3, ov3;
  logic [W-1:0] ob3;
  logic [1:0]   cnt3;

  pipe_stage_buf #(.BUS_W(W), .DEPTH(2)) dut2 (
    .clk(clk), .reset(r2), .in_valid(iv2), .in_bus(ib2), .allowin(al2),
    .out_valid(ov2), .out_bus(ob2), .out_allowin(oa2), .flush(fl2), .count(cnt2)
  );

  pipe_stage_buf #(.BUS_W(W), .DEPTH(3)) dut3 (
    .clk(clk), .reset(r3), .in_valid(iv3), .in_bus(ib3), .allowin(al3),
    .out_valid(ov3), .out_bus(ob3), .out_allowin(oa3), .flush(fl3), .count(cnt3)
  );

  int tests = 0;
  int fails = 0;

`ifdef PIPE_STAGE_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge, outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] q[$];
    logic [W-1:0] exp_bus;
    logic exp_ov, exp_al, exp_pop, do_push, hold, bp;

    r2 = 1'b1; iv2 = 1'b1; ib2 = 16'h00EE; oa2 = 1'b0; fl2 = 1'b0;
    r3 = 1'b1; iv3 = 1'b0; ib3 = '0;       oa3 = 1'b0; fl3 = 1'b0;

    // 1. reset held 3 cycles with in_valid asserted
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("rst_allowin", al2, 0);
      chk("rst_out_valid", ov2, 0);
      chk("rst_count", cnt2, 0);
    end
    tick();
    r2 = 1'b0; r3 = 1'b0; iv2 = 1'b0;
    #1;
    chk("post_rst_allowin", al2, 1);
    chk("post_rst_count", cnt2, 0);

    // 2. fill while stalled, then drain in order
    oa2 = 1'b0; iv2 = 1'b1; ib2 = 16'h00A1;
    #1 chk("fill_al_1", al2, 1);
    tick(); ib2 = 16'h00A2;
    #1 chk("fill_al_2", al2, 1);
    chk("fill_ov_2", ov2, 1);
    tick(); ib2 = 16'h00A3;
    #1 chk("fill_al_3", al2, 0);
    chk("fill_cnt", cnt2, 2);
    tick(); chk("stall_cnt", cnt2, 2);
    oa2 = 1'b1;
    #1 chk("drain_bus_a1", ob2, 16'h00A1);
    chk("drain_al_fullpop", al2, 1);
    tick(); iv2 = 1'b0;
    #1 chk("drain_cnt_after_swap", cnt2, 2);
    chk("drain_bus_a2", ob2, 16'h00A2);
    tick();
    #1 chk("drain_bus_a3", ob2, 16'h00A3);
    chk("drain_ov_a3", ov2, 1);
    tick(); oa2 = 1'b0;
    #1 chk("drain_empty_ov", ov2, 0);
    chk("drain_empty_cnt", cnt2, 0);

    // 3. full with back-to-back push+pop, pointers wrap
    iv2 = 1'b1; ib2 = 16'h00D0;
    tick(); ib2 = 16'h00D1;
    tick();
    #1 chk("b2b_full_cnt", cnt2, 2);
    oa2 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ib2 = W'(16'h00D2 + k);
      #1;
      chk("b2b_allowin", al2, 1);
      chk("b2b_bus", ob2, 16'h00D0 + k);
      chk("b2b_cnt", cnt2, 2);
      tick();
    end
    iv2 = 1'b0;
    #1 chk("b2b_tail0", ob2, 16'h00D5);
    tick();
    #1 chk("b2b_tail1", ob2, 16'h00D6);
    tick(); oa2 = 1'b0;
    #1 chk("b2b_empty", cnt2, 0);

    // 4. flush while full with a pending push of 0xB0
    iv2 = 1'b1; ib2 = 16'h00E0;
    tick(); ib2 = 16'h00E1;
    tick();
    fl2 = 1'b1; ib2 = 16'h00B0; oa2 = 1'b1;
    #1 chk("flush_ov", ov2, 0);
    tick(); fl2 = 1'b0; iv2 = 1'b0; oa2 = 1'b0;
    #1 chk("flush_cnt", cnt2, 0);
    chk("flush_ov_after", ov2, 0);
    iv2 = 1'b1; ib2 = 16'h00F0;
    tick(); iv2 = 1'b0;
    #1 chk("flush_next_bus", ob2, 16'h00F0);
    chk("flush_next_cnt", cnt2, 1);
    oa2 = 1'b1;
    tick(); oa2 = 1'b0;
    #1 chk("flush_drained", cnt2, 0);

    // 5. empty-buffer latency (bypass or one cycle)
    iv2 = 1'b1; ib2 = 16'h00C5; oa2 = 1'b1;
    #1;
    if (BYP) begin
      chk("byp_ov", ov2, 1);
      chk("byp_bus", ob2, 16'h00C5);
      tick(); iv2 = 1'b0;
      #1 chk("byp_cnt", cnt2, 0);
      chk("byp_ov_after", ov2, 0);
    end else begin
      chk("lat_ov0", ov2, 0);
      tick(); iv2 = 1'b0;
      #1 chk("lat_cnt1", cnt2, 1);
      chk("lat_ov1", ov2, 1);
      chk("lat_bus", ob2, 16'h00C5);
      tick();
      #1 chk("lat_cnt0", cnt2, 0);
    end
    oa2 = 1'b0;

    // reset in the middle of operation
    iv2 = 1'b1; ib2 = 16'h0011;
    tick(); ib2 = 16'h0012;
    tick(); iv2 = 1'b0; r2 = 1'b1; oa2 = 1'b1;
    #1 chk("midrst_allowin", al2, 0);
    chk("midrst_ov", ov2, 0);
    tick(); r2 = 1'b0; oa2 = 1'b0;
    #1 chk("midrst_cnt", cnt2, 0);
    chk("midrst_ov_after", ov2, 0);

    // 6. DEPTH=3 random traffic against a queue model
    hold = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (!hold) begin
        iv3 = ($urandom_range(0, 99) < 60);
        ib3 = W'($urandom);
      end
      oa3 = ($urandom_range(0, 99) < 50);
      fl3 = ($urandom_range(0, 31) == 0);
      #1;
      bp      = BYP && (q.size() == 0) && iv3 && !fl3;
      exp_ov  = !fl3 && ((q.size() > 0) || bp);
      exp_bus = (q.size() > 0) ? q[0] : ib3;
      exp_pop = exp_ov && oa3;
      exp_al  = (q.size() < 3) || exp_pop;
      do_push = iv3 && exp_al && !fl3;
      chk("rnd_cnt", cnt3, q.size());
      chk("rnd_cnt_le_depth", (cnt3 <= 2'd3), 1);
      chk("rnd_allowin", al3, exp_al);
      chk("rnd_out_valid", ov3, exp_ov);
      if (exp_ov) chk("rnd_out_bus", ob3, exp_bus);
      if (fl3) begin
        q.delete();
      end else if (!(exp_pop && q.size() == 0)) begin
        if (exp_pop) void'(q.pop_front());
        if (do_push) q.push_back(ib3);
      end
      hold = iv3 && !do_push && !fl3;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
